// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_scanner_pkg;

    localparam int SCAN_DIV_DEF = 1000;
    localparam int DEBOUNCE_DEF = 50000;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } scan_state_t;

    // Indexed by {row, col}: row0 1,2,3,A / row1 4,5,6,B / row2 7,8,9,C / row3 E,0,F,D
    localparam logic [15:0][3:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    function automatic logic [1:0] first_low(input logic [3:0] rows);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad rows.
module row_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] row_s
);

    logic [3:0] meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta  <= 4'hF;
            row_s <= 4'hF;
        end else begin
            meta  <= row_in;
            row_s <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad decoder with press and release debounce.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV        = SCAN_DIV_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_value,
    output logic       key_pressed
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

    scan_state_t   state;
    logic [1:0]    col;
    logic [1:0]    row;
    logic [1:0]    next_col;
    logic [DW-1:0] dwell;
    logic [BW-1:0] deb_cnt;
    logic [3:0]    row_s;
    logic          row_hit;

    row_sync u_row_sync (
        .clk    (clk),
        .rst    (rst),
        .row_in (row_in),
        .row_s  (row_s)
    );

    assign next_col = col + 2'd1;
    // Only the captured row matters once a key is being tracked
    assign row_hit  = ~row_s[row];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= SCAN;
            col         <= 2'd0;
            row         <= 2'd0;
            dwell       <= '0;
            deb_cnt     <= '0;
            col_out     <= 4'b1110;
            key_value   <= 4'h0;
            key_pressed <= 1'b0;
        end else begin
            unique case (state)
                SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (row_s != 4'hF) begin
                            row     <= first_low(row_s);
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            col     <= next_col;
                            col_out <= col_drive(next_col);
                        end
                    end else begin
                        dwell <= dwell + DW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!row_hit) begin
                        state   <= SCAN;
                        col     <= next_col;
                        col_out <= col_drive(next_col);
                    end else if (deb_cnt == DEB_LAST) begin
                        key_value   <= KEY_MAP[{row, col}];
                        key_pressed <= 1'b1;
                        state       <= HELD;
                    end else begin
                        deb_cnt <= deb_cnt + BW'(1);
                    end
                end
                HELD: begin
                    if (!row_hit) begin
                        deb_cnt <= '0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (row_hit) begin
                        deb_cnt <= '0;
                        state   <= HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        key_pressed <= 1'b0;
                        state       <= SCAN;
                        col         <= next_col;
                        col_out     <= col_drive(next_col);
                    end else begin
                        deb_cnt <= deb_cnt + BW'(1);
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

    typedef struct packed {
        logic       kp;
        logic [3:0] kv;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_value;
    logic       key_pressed;
    logic [3:0][3:0] pressed;
    logic       prev_kp = 1'b0;
    ev_t        exp_q[$];
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row_in      (row_in),
        .col_out     (col_out),
        .key_value   (key_value),
        .key_pressed (key_pressed)
    );

    // A row reads low only when its pressed key sits on the driven column
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r][c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col(input logic [3:0] target);
        int n;
        n = 0;
        while (col_out == target && n < 64) begin
            @(negedge clk);
            n++;
        end
        while (col_out != target && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            tests++;
            fails++;
            $display("FAIL wait_col: got %b expected %b", col_out, target);
        end
    endtask

    // Monitor: every key_pressed transition must match the next expected event
    always @(negedge clk) begin
        if (key_pressed !== prev_kp) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_edge: got kp=%b kv=%h expected no edge",
                         key_pressed, key_value);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("kp_event", {3'b0, key_pressed, key_value}, {3'b0, e.kp, e.kv});
            end
            prev_kp = key_pressed;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        pressed = '0;
        tick(3);
        check("rst_col", 8'(col_out), 8'b1110);
        check("rst_kp", 8'(key_pressed), 8'h0);
        check("rst_kv", 8'(key_value), 8'h0);
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] exp_col;
            tick(1);
            exp_col = ~(4'b0001 << (((k + 1) / 4) % 4));
            check("scan_col", 8'(col_out), 8'(exp_col));
        end

        // Clean press of '6' on row1/col2
        exp_q.push_back(ev_t'{1'b1, 4'h6});
        wait_col(4'b1011);
        pressed[1][2] = 1'b1;
        tick(11);
        check("press_early_kp", 8'(key_pressed), 8'h0);
        check("press_frozen_col", 8'(col_out), 8'b1011);
        tick(1);
        check("press_kp", 8'(key_pressed), 8'h1);
        check("press_kv", 8'(key_value), 8'h6);
        tick(8);
        check("press_hold_col", 8'(col_out), 8'b1011);
        pressed[1][2] = 1'b0;
        exp_q.push_back(ev_t'{1'b0, 4'h6});
        tick(10);
        check("release_early_kp", 8'(key_pressed), 8'h1);
        tick(1);
        check("release_kp", 8'(key_pressed), 8'h0);
        check("release_kv_hold", 8'(key_value), 8'h6);
        check("release_next_col", 8'(col_out), 8'b0111);

        // Bounce on row0/col0
        wait_col(4'b1110);
        pressed[0][0] = 1'b1;
        tick(5);
        check("bounce_frozen", 8'(col_out), 8'b1110);
        pressed[0][0] = 1'b0;
        tick(2);
        check("bounce_still", 8'(col_out), 8'b1110);
        tick(1);
        check("bounce_resume", 8'(col_out), 8'b1101);
        check("bounce_kp", 8'(key_pressed), 8'h0);

        // Key '0' held, short release glitch, then real release
        exp_q.push_back(ev_t'{1'b1, 4'h0});
        wait_col(4'b1101);
        pressed[3][1] = 1'b1;
        tick(14);
        check("zero_kp", 8'(key_pressed), 8'h1);
        pressed[3][1] = 1'b0;
        tick(4);
        pressed[3][1] = 1'b1;
        tick(6);
        check("glitch_kp", 8'(key_pressed), 8'h1);
        check("glitch_col", 8'(col_out), 8'b1101);
        pressed[3][1] = 1'b0;
        exp_q.push_back(ev_t'{1'b0, 4'h0});
        tick(12);
        check("zero_rel_kp", 8'(key_pressed), 8'h0);
        check("zero_rel_kv", 8'(key_value), 8'h0);

        // Two keys on col3: lowest row wins, lifting the other is ignored
        exp_q.push_back(ev_t'{1'b1, 4'hA});
        wait_col(4'b0111);
        pressed[0][3] = 1'b1;
        pressed[2][3] = 1'b1;
        tick(14);
        check("two_kv", 8'(key_value), 8'hA);
        pressed[2][3] = 1'b0;
        tick(20);
        check("two_lift_kp", 8'(key_pressed), 8'h1);
        check("two_lift_kv", 8'(key_value), 8'hA);
        pressed[0][3] = 1'b0;
        exp_q.push_back(ev_t'{1'b0, 4'hA});
        tick(12);
        check("two_rel_kp", 8'(key_pressed), 8'h0);

        // Reset while 'D' is held
        exp_q.push_back(ev_t'{1'b1, 4'hD});
        wait_col(4'b0111);
        pressed[3][3] = 1'b1;
        tick(14);
        check("d_kv", 8'(key_value), 8'hD);
        exp_q.push_back(ev_t'{1'b0, 4'h0});
        rst = 1'b0;
        tick(1);
        check("rst_held_kp", 8'(key_pressed), 8'h0);
        check("rst_held_kv", 8'(key_value), 8'h0);
        check("rst_held_col", 8'(col_out), 8'b1110);
        pressed[3][3] = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(20);
        check("post_rst_kp", 8'(key_pressed), 8'h0);

        tick(5);
        check("queue_drain", 8'(exp_q.size()), 8'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clk cycles each column is driven before advancing (legal range >= 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable clk cycles required to accept a press or a release (legal range >= 2).
REQ-003 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port row_in, input, 4: keypad rows; asynchronous, pulled up, low while a key on the driven column is down.
REQ-006 SHALL have port col_out, output, 4: column drive, one-hot active-low.
REQ-007 SHALL have port key_value, output, 4: hex code of the accepted key; feeds the accumulator stage.
REQ-008 SHALL have port key_pressed, output, 1: level signal, high from accepted press until accepted release.

Function
REQ-009 SHALL pass row_in through a 2-flop synchronizer; only the synchronized value (row_s) is used.
REQ-010 SHALL implement the FSM states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-011 In SCAN, SHALL drive column c low for SCAN_DIV cycles, then advance c in the order 0->1->2->3->0.
REQ-012 In SCAN, on the last dwell cycle of column c, SHALL sample row_s; if any bit is 0, SHALL capture c and the lowest-index low row r, freeze col_out, and enter DEBOUNCE.
REQ-013 In DEBOUNCE, SHALL count cycles with row_s[r]=0; on reaching DEBOUNCE_CYCLES, SHALL load key_value, set key_pressed=1 in the same cycle, and enter HELD.
REQ-014 In DEBOUNCE, if row_s[r]=1 before the count completes, SHALL leave key_value and key_pressed unchanged, enter SCAN, and resume at column c+1 mod 4.
REQ-015 In HELD, SHALL keep col_out frozen and key_pressed=1; row_s[r]=1 SHALL cause entry to RELEASE with the counter cleared.
REQ-016 In RELEASE, SHALL count cycles with row_s[r]=1; on reaching DEBOUNCE_CYCLES, SHALL clear key_pressed and enter SCAN at column c+1 mod 4.
REQ-017 In RELEASE, if row_s[r]=0, SHALL return to HELD with key_pressed kept at 1 and no new key_value.
REQ-018 Key map (row, col) -> key_value: row0 1,2,3,A; row1 4,5,6,B; row2 7,8,9,C; row3 E(*),0,F(#),D.
REQ-019 While in DEBOUNCE, HELD or RELEASE, SHALL ignore keys on other rows or columns; key_pressed SHALL rise only once per accepted press.
REQ-020 key_value SHALL hold the last accepted key after release until the next accepted press.
REQ-021 Counters SHALL be sized $clog2 of the respective parameter and SHALL never wrap inside a state.

Reset
REQ-022 On rst=0 at a clk edge, SHALL set state=SCAN, column 0, col_out=4'b1110, dwell and debounce counters to 0, key_value=4'h0, key_pressed=0, and synchronizer flops to 4'hF.
REQ-023 Reset asserted in any state, including mid-debounce or while HELD, SHALL take effect on the next edge with no pulse or glitch on key_pressed.

Structure
REQ-024 The shared package SHALL hold the FSM state enum, the 16-entry key map constant, and the defaults for SCAN_DIV and DEBOUNCE_CYCLES.
REQ-025 Sub-module row_sync SHALL contain the 2-flop synchronizer for row_in[3:0]; all other logic SHALL stay in keypad_scanner.

Verification (bench: SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-026 Reset: hold rst=0 for 3 cycles -> col_out=1110, key_pressed=0, key_value=0; after release, col_out steps 1110->1101->1011->0111 every 4 cycles.
REQ-027 Clean press: hold row1 low while col2 is driven, for 20 cycles -> key_value=6, key_pressed rises 8 cycles after debounce entry, col_out stays 1011.
REQ-028 Bounce: hold row0 low on col0 for 5 cycles, then release -> key_pressed stays 0, scan resumes at col1.
REQ-029 Release glitch: key '0' HELD, then row3 high for 4 cycles and low again -> key_pressed stays 1; after a 9-cycle high, key_pressed=0 and key_value stays 0.
REQ-030 Two keys: rows 0 and 2 both low on col3 -> key_value=A; row2 lifted while row0 held -> no second rising edge.
REQ-031 Reset mid-HELD: key 'D' held, then rst=0 -> next edge key_pressed=0, key_value=0, col_out=1110.
